stopwatch_lap_timer: RTL and testbench

- Parametrised BCD MM..M:SS stopwatch/countdown timer.
- Adds the following to the fixed 4-digit stopwatch:
  - configurable minute-digit count;
  - internal tick divider with fast mode;
  - explicit run/pause/done state machine;
  - saturating minute adjust;
  - lap capture.
- Sits between the board clock and the 7-segment display mux.
- Q feeds the display decoder directly.

---
 rtl/stopwatch_lap_timer.sv | 206 ++++++++++++++++++++
 tb/tb_stopwatch_lap_timer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_lap_timer.sv
// BCD MM..M:SS stopwatch / countdown timer with internal tick divider, fast mode,
// run/pause/done state machine, saturating minute adjust and lap capture.
module stopwatch_lap_timer #(
    parameter int unsigned                MIN_DIGITS = 2,
    parameter int unsigned                TICK_DIV   = 50000000,
    parameter int unsigned                FAST_SHIFT = 2,
    parameter logic [8+4*MIN_DIGITS-1:0] UP_LIMIT   = 'h5959,
    parameter logic [8+4*MIN_DIGITS-1:0] DOWN_START = 'h1000
) (
    input  logic                        clk_in,
    input  logic                        RESET,
    input  logic                        START,
    input  logic                        PRESET,
    input  logic                        REVERSE,
    input  logic                        SPEED_UP,
    input  logic                        ADD,
    input  logic                        SUBTRACT,
    input  logic                        LAP,
    output logic [8+4*MIN_DIGITS-1:0]  Q,
    output logic [8+4*MIN_DIGITS-1:0]  LAP_Q,
    output logic                        LAP_VALID,
    output logic                        DONE,
    output logic                        RUNNING
);

    localparam int unsigned W        = 8 + 4 * MIN_DIGITS;
    localparam int unsigned MW       = 4 * MIN_DIGITS;
    localparam int unsigned DIV_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned FAST_RAW = TICK_DIV >> FAST_SHIFT;
    localparam int unsigned FAST_P   = (FAST_RAW == 0) ? 1 : FAST_RAW;

    localparam logic [DIV_W-1:0] SLOW_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] FAST_LAST = DIV_W'(FAST_P - 1);
    localparam logic [MW-1:0]    MIN_MAX   = {MIN_DIGITS{4'h9}};

    typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

    state_e           state_q, state_d;
    logic [W-1:0]     q_q, q_d;
    logic [W-1:0]     lap_q_q, lap_q_d;
    logic             lap_valid_q, lap_valid_d;
    logic             done_q, done_d;
    logic             running_q, running_d;
    logic             dir_q, dir_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] div_last;
    logic [W-1:0]     q_tick;

    function automatic logic [MW-1:0] min_inc(input logic [MW-1:0] m);
        logic [MW-1:0] r;
        logic          carry;
        r     = m;
        carry = 1'b1;
        for (int i = 0; i < int'(MIN_DIGITS); i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [MW-1:0] min_dec(input logic [MW-1:0] m);
        logic [MW-1:0] r;
        logic          borrow;
        r      = m;
        borrow = 1'b1;
        for (int i = 0; i < int'(MIN_DIGITS); i++) begin
            if (borrow) begin
                if (r[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] time_inc(input logic [W-1:0] t);
        logic [W-1:0] r;
        r = t;
        if (r[3:0] != 4'd9) begin
            r[3:0] = r[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (r[7:4] != 4'd5) begin
                r[7:4] = r[7:4] + 4'd1;
            end else begin
                r[7:4]   = 4'd0;
                r[W-1:8] = min_inc(r[W-1:8]);
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] time_dec(input logic [W-1:0] t);
        logic [W-1:0] r;
        r = t;
        if (r[3:0] != 4'd0) begin
            r[3:0] = r[3:0] - 4'd1;
        end else begin
            r[3:0] = 4'd9;
            if (r[7:4] != 4'd0) begin
                r[7:4] = r[7:4] - 4'd1;
            end else begin
                r[7:4]   = 4'd5;
                r[W-1:8] = min_dec(r[W-1:8]);
            end
        end
        return r;
    endfunction

    assign div_last = SPEED_UP ? FAST_LAST : SLOW_LAST;
    assign q_tick   = dir_q ? time_dec(q_q) : time_inc(q_q);

    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        dir_d       = dir_q;
        div_d       = '0;
        lap_q_d     = lap_q_q;
        lap_valid_d = 1'b0;

        // Lap samples the pre-update value and is independent of the other controls.
        if (LAP && (state_q == StRun || state_q == StPause)) begin
            lap_q_d     = q_q;
            lap_valid_d = 1'b1;
        end

        if (PRESET) begin
            q_d     = REVERSE ? DOWN_START : '0;
            dir_d   = REVERSE;
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StPause: begin
                    if (START) begin
                        state_d = StRun;
                        if (state_q == StIdle) begin
                            dir_d = REVERSE;
                            if (REVERSE && q_q == '0) begin
                                state_d = StDone;
                            end
                        end
                    end else if (ADD && !SUBTRACT) begin
                        if (q_q[W-1:8] != MIN_MAX) q_d[W-1:8] = min_inc(q_q[W-1:8]);
                    end else if (SUBTRACT && !ADD) begin
                        if (q_q[W-1:8] != '0) q_d[W-1:8] = min_dec(q_q[W-1:8]);
                    end
                end
                StRun: begin
                    if (START) begin
                        state_d = StPause;
                    end else if (div_q >= div_last) begin
                        q_d = q_tick;
                        if (dir_q ? (q_tick == '0) : (q_tick == UP_LIMIT)) begin
                            state_d = StDone;
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                StDone: ;
                default: state_d = StIdle;
            endcase
        end

        done_d    = (state_d == StDone);
        running_d = (state_d == StRun);
    end

    always_ff @(posedge clk_in) begin
        if (RESET) begin
            state_q     <= StIdle;
            q_q         <= '0;
            lap_q_q     <= '0;
            lap_valid_q <= 1'b0;
            done_q      <= 1'b0;
            running_q   <= 1'b0;
            dir_q       <= 1'b0;
            div_q       <= '0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            lap_q_q     <= lap_q_d;
            lap_valid_q <= lap_valid_d;
            done_q      <= done_d;
            running_q   <= running_d;
            dir_q       <= dir_d;
            div_q       <= div_d;
        end
    end

    assign Q         = q_q;
    assign LAP_Q     = lap_q_q;
    assign LAP_VALID = lap_valid_q;
    assign DONE      = done_q;
    assign RUNNING   = running_q;

endmodule

// File: tb/tb_stopwatch_lap_timer.sv
// Directed bench for stopwatch_lap_timer: TICK_DIV=4, FAST_SHIFT=1, two minute digits,
// UP_LIMIT=0102, expected values hand-computed.
module tb_stopwatch_lap_timer;

    localparam int unsigned W = 16;

    logic         clk_in = 1'b0;
    logic         RESET = 1'b0, START = 1'b0, PRESET = 1'b0, REVERSE = 1'b0;
    logic         SPEED_UP = 1'b0, ADD = 1'b0, SUBTRACT = 1'b0, LAP = 1'b0;
    logic [W-1:0] Q, LAP_Q;
    logic         LAP_VALID, DONE, RUNNING;

    int checks = 0;
    int errors = 0;

    stopwatch_lap_timer #(
        .MIN_DIGITS (2),
        .TICK_DIV   (4),
        .FAST_SHIFT (1),
        .UP_LIMIT   (16'h0102),
        .DOWN_START (16'h1000)
    ) dut (
        .clk_in    (clk_in),
        .RESET     (RESET),
        .START     (START),
        .PRESET    (PRESET),
        .REVERSE   (REVERSE),
        .SPEED_UP  (SPEED_UP),
        .ADD       (ADD),
        .SUBTRACT  (SUBTRACT),
        .LAP       (LAP),
        .Q         (Q),
        .LAP_Q     (LAP_Q),
        .LAP_VALID (LAP_VALID),
        .DONE      (DONE),
        .RUNNING   (RUNNING)
    );

    always #5 clk_in = ~clk_in;

    // Advance n rising edges; inputs change and outputs are sampled 1ns after an edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // Test 1: reset state, up-count, carry, terminal
        RESET = 1'b1; step(1); RESET = 1'b0;
        check("rst_q", Q, 16'h0000);
        check("rst_lap_q", LAP_Q, 16'h0000);
        check("rst_lap_valid", {15'd0, LAP_VALID}, 16'd0);
        check("rst_done", {15'd0, DONE}, 16'd0);
        check("rst_running", {15'd0, RUNNING}, 16'd0);

        START = 1'b1; step(1); START = 1'b0;
        check("t1_running", {15'd0, RUNNING}, 16'd1);
        step(3);
        check("t1_no_tick_yet", Q, 16'h0000);
        step(1);
        check("t1_first_tick", Q, 16'h0001);
        step(4 * 58);
        check("t1_0059", Q, 16'h0059);
        step(4);
        check("t1_carry_0100", Q, 16'h0100);
        step(4);
        check("t1_0101", Q, 16'h0101);
        check("t1_not_done", {15'd0, DONE}, 16'd0);
        step(4);
        check("t1_terminal", Q, 16'h0102);
        check("t1_done", {15'd0, DONE}, 16'd1);
        check("t1_stopped", {15'd0, RUNNING}, 16'd0);
        START = 1'b1; step(1); START = 1'b0;
        step(5);
        check("t1_start_ignored_q", Q, 16'h0102);
        check("t1_start_ignored_done", {15'd0, DONE}, 16'd1);

        // Test 2: countdown from preset with minute adjust
        REVERSE = 1'b1;
        PRESET = 1'b1; step(1); PRESET = 1'b0;
        check("t2_preset", Q, 16'h1000);
        check("t2_preset_done", {15'd0, DONE}, 16'd0);
        repeat (9) begin
            SUBTRACT = 1'b1; step(1); SUBTRACT = 1'b0;
        end
        check("t2_adjusted", Q, 16'h0100);
        START = 1'b1; step(1); START = 1'b0;
        step(4);
        check("t2_borrow_0059", Q, 16'h0059);
        step(4);
        check("t2_0058", Q, 16'h0058);
        step(4 * 57);
        check("t2_0001", Q, 16'h0001);
        check("t2_not_done", {15'd0, DONE}, 16'd0);
        step(4);
        check("t2_zero", Q, 16'h0000);
        check("t2_done", {15'd0, DONE}, 16'd1);
        check("t2_stopped", {15'd0, RUNNING}, 16'd0);

        // Test 3: fast mode; raising SPEED_UP with divider already past the fast limit
        REVERSE = 1'b0;
        PRESET = 1'b1; step(1); PRESET = 1'b0;
        START = 1'b1; step(1); START = 1'b0;
        step(4);
        check("t3_0001", Q, 16'h0001);
        step(2);
        SPEED_UP = 1'b1;
        step(1);
        check("t3_fast_immediate", Q, 16'h0002);
        step(1);
        check("t3_fast_hold", Q, 16'h0002);
        step(1);
        check("t3_fast_period2", Q, 16'h0003);
        SPEED_UP = 1'b0;
        step(3);
        check("t3_slow_hold", Q, 16'h0003);
        step(1);
        check("t3_slow_tick", Q, 16'h0004);

        // Test 4: pause, adjust, saturation, adjust ignored in RUN
        step(4 * 8);
        check("t4_0012", Q, 16'h0012);
        START = 1'b1; step(1); START = 1'b0;
        check("t4_paused", {15'd0, RUNNING}, 16'd0);
        step(6);
        check("t4_pause_hold", Q, 16'h0012);
        ADD = 1'b1; step(1); ADD = 1'b0;
        check("t4_add", Q, 16'h0112);
        ADD = 1'b1; SUBTRACT = 1'b1; step(1); ADD = 1'b0; SUBTRACT = 1'b0;
        check("t4_add_sub", Q, 16'h0112);
        repeat (2) begin
            SUBTRACT = 1'b1; step(1); SUBTRACT = 1'b0;
        end
        check("t4_sub_saturate", Q, 16'h0012);
        START = 1'b1; step(1); START = 1'b0;
        ADD = 1'b1; step(1); ADD = 1'b0;
        check("t4_add_in_run", Q, 16'h0012);
        check("t4_running", {15'd0, RUNNING}, 16'd1);

        // Test 5: lap capture on a tick edge, retained across preset, ignored in IDLE
        PRESET = 1'b1; step(1); PRESET = 1'b0;
        START = 1'b1; step(1); START = 1'b0;
        step(4 * 7);
        check("t5_0007", Q, 16'h0007);
        step(3);
        LAP = 1'b1; step(1); LAP = 1'b0;
        check("t5_tick", Q, 16'h0008);
        check("t5_lap_q", LAP_Q, 16'h0007);
        check("t5_lap_valid", {15'd0, LAP_VALID}, 16'd1);
        step(1);
        check("t5_lap_valid_drop", {15'd0, LAP_VALID}, 16'd0);
        PRESET = 1'b1; step(1); PRESET = 1'b0;
        check("t5_lap_retained", LAP_Q, 16'h0007);
        LAP = 1'b1; step(1); LAP = 1'b0;
        check("t5_idle_lap_valid", {15'd0, LAP_VALID}, 16'd0);
        check("t5_idle_lap_q", LAP_Q, 16'h0007);

        // Test 6: immediate DONE on zero countdown, PRESET over START, reset mid-run
        REVERSE = 1'b1;
        START = 1'b1; step(1); START = 1'b0;
        check("t6_zero_done", {15'd0, DONE}, 16'd1);
        check("t6_zero_q", Q, 16'h0000);
        REVERSE = 1'b0;
        PRESET = 1'b1; step(1); PRESET = 1'b0;
        START = 1'b1; step(1); START = 1'b0;
        step(8);
        check("t6_0002", Q, 16'h0002);
        REVERSE = 1'b1; PRESET = 1'b1; START = 1'b1; step(1); PRESET = 1'b0; START = 1'b0;
        check("t6_preset_wins_q", Q, 16'h1000);
        check("t6_preset_wins_run", {15'd0, RUNNING}, 16'd0);
        step(5);
        check("t6_idle_hold", Q, 16'h1000);
        REVERSE = 1'b0;
        PRESET = 1'b1; step(1); PRESET = 1'b0;
        START = 1'b1; step(1); START = 1'b0;
        step(4 * 33);
        check("t6_0033", Q, 16'h0033);
        RESET = 1'b1; step(1); RESET = 1'b0;
        check("t6_rst_q", Q, 16'h0000);
        check("t6_rst_lap_q", LAP_Q, 16'h0000);
        check("t6_rst_running", {15'd0, RUNNING}, 16'd0);
        step(4);
        check("t6_rst_idle", Q, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
